// File: rtl/fetch_predictor.sv
// Instruction-fetch stage: owns the PC, predicts next-PC with a direct-mapped BTB
// (2-bit counters), fetches the MIPS delay slot, and repairs mispredictions from decode.
module fetch_predictor #(
   parameter int          BTB_IDX_BITS = 6,
   parameter logic [31:0] RESET_PC     = 32'h0040_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic [31:0] Instr_Address_OUT,
   input  logic [31:0] Instr_Data_IN,
   input  logic        Freeze_IN,
   input  logic        Resolve_Valid_IN,
   input  logic [31:0] Resolve_PC_IN,
   input  logic        Resolve_Taken_IN,
   input  logic [31:0] Resolve_Target_IN,
   output logic [31:0] Instr_OUT,
   output logic [31:0] Instr_PC_OUT,
   output logic [31:0] Instr_PC_Plus4_OUT,
   output logic        Pred_Taken_OUT,
   output logic [31:0] Mispredict_Count_OUT
);

   localparam int ENTRIES  = 1 << BTB_IDX_BITS;
   localparam int TAG_BITS = 30 - BTB_IDX_BITS;

   logic [31:0]         pc_r;
   logic                pend_r;
   logic [31:0]         pend_target_r;
   logic [31:0]         stage_target_r;
   logic                shadow_taken_r;
   logic [31:0]         shadow_target_r;

   logic                btb_valid_r  [ENTRIES];
   logic [TAG_BITS-1:0] btb_tag_r    [ENTRIES];
   logic [31:0]         btb_target_r [ENTRIES];
   logic [1:0]          btb_ctr_r    [ENTRIES];

   logic [BTB_IDX_BITS-1:0] lk_idx_s;
   logic [TAG_BITS-1:0]     lk_tag_s;
   logic                    lk_hit_s;
   logic [31:0]             lk_target_s;
   logic                    predict_s;

   logic [BTB_IDX_BITS-1:0] up_idx_s;
   logic [TAG_BITS-1:0]     up_tag_s;
   logic                    up_hit_s;
   logic [1:0]              up_ctr_s;

   logic        mispredict_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] redirect_pc_s;

   logic [31:0] pc_nxt_s;
   logic        pend_nxt_s;
   logic [31:0] pend_target_nxt_s;
   logic [31:0] stage_target_nxt_s;
   logic [31:0] instr_nxt_s;
   logic [31:0] instr_pc_nxt_s;
   logic [31:0] instr_pc4_nxt_s;
   logic        pred_nxt_s;
   logic [31:0] count_nxt_s;
   logic        shadow_adv_s;

   assign Instr_Address_OUT = pc_r;

   // BTB lookup on the fetch PC and on the resolving PC, plus mispredict detection
   always_comb begin
      lk_idx_s      = pc_r[BTB_IDX_BITS+1:2];
      lk_tag_s      = pc_r[31:BTB_IDX_BITS+2];
      lk_hit_s      = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
      lk_target_s   = btb_target_r[lk_idx_s];
      predict_s     = lk_hit_s && btb_ctr_r[lk_idx_s][1] && !pend_r;

      up_idx_s      = Resolve_PC_IN[BTB_IDX_BITS+1:2];
      up_tag_s      = Resolve_PC_IN[31:BTB_IDX_BITS+2];
      up_hit_s      = btb_valid_r[up_idx_s] && (btb_tag_r[up_idx_s] == up_tag_s);
      up_ctr_s      = btb_ctr_r[up_idx_s];

      mispredict_s  = Resolve_Valid_IN &&
                      ((Resolve_Taken_IN != shadow_taken_r) ||
                       (Resolve_Taken_IN && (Resolve_Target_IN != shadow_target_r)));
      pc_plus4_s    = pc_r + 32'd4;
      redirect_pc_s = Resolve_Taken_IN ? Resolve_Target_IN : (Resolve_PC_IN + 32'd8);
   end

   // Next-state selection: mispredict repair beats freeze, freeze beats normal fetch
   always_comb begin
      pc_nxt_s           = pc_r;
      pend_nxt_s         = pend_r;
      pend_target_nxt_s  = pend_target_r;
      stage_target_nxt_s = stage_target_r;
      instr_nxt_s        = Instr_OUT;
      instr_pc_nxt_s     = Instr_PC_OUT;
      instr_pc4_nxt_s    = Instr_PC_Plus4_OUT;
      pred_nxt_s         = Pred_Taken_OUT;
      count_nxt_s        = Mispredict_Count_OUT;
      shadow_adv_s       = 1'b0;
      if (mispredict_s) begin
         pc_nxt_s     = redirect_pc_s;
         pend_nxt_s   = 1'b0;
         instr_nxt_s  = 32'd0;
         pred_nxt_s   = 1'b0;
         count_nxt_s  = Mispredict_Count_OUT + 32'd1;
         shadow_adv_s = 1'b1;
         if (!Freeze_IN) begin
            instr_pc_nxt_s     = pc_r;
            instr_pc4_nxt_s    = pc_plus4_s;
            stage_target_nxt_s = lk_target_s;
         end else begin
            instr_pc_nxt_s     = Instr_PC_OUT;
            instr_pc4_nxt_s    = Instr_PC_Plus4_OUT;
            stage_target_nxt_s = stage_target_r;
         end
      end else if (!Freeze_IN) begin
         instr_nxt_s        = Instr_Data_IN;
         instr_pc_nxt_s     = pc_r;
         instr_pc4_nxt_s    = pc_plus4_s;
         pred_nxt_s         = predict_s;
         stage_target_nxt_s = lk_target_s;
         shadow_adv_s       = 1'b1;
         // A predicted branch still fetches its delay slot before jumping
         if (pend_r) begin
            pc_nxt_s   = pend_target_r;
            pend_nxt_s = 1'b0;
         end else if (predict_s) begin
            pc_nxt_s          = pc_plus4_s;
            pend_nxt_s        = 1'b1;
            pend_target_nxt_s = lk_target_s;
         end else begin
            pc_nxt_s = pc_plus4_s;
         end
      end else begin
         shadow_adv_s = 1'b0;
      end
   end

   // Fetch-stage state, decode-facing outputs and the resolve shadow
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc_r                 <= RESET_PC;
         pend_r               <= 1'b0;
         pend_target_r        <= 32'd0;
         stage_target_r       <= 32'd0;
         shadow_taken_r       <= 1'b0;
         shadow_target_r      <= 32'd0;
         Instr_OUT            <= 32'd0;
         Instr_PC_OUT         <= 32'd0;
         Instr_PC_Plus4_OUT   <= 32'd0;
         Pred_Taken_OUT       <= 1'b0;
         Mispredict_Count_OUT <= 32'd0;
      end else begin
         pc_r                 <= pc_nxt_s;
         pend_r               <= pend_nxt_s;
         pend_target_r        <= pend_target_nxt_s;
         stage_target_r       <= stage_target_nxt_s;
         Instr_OUT            <= instr_nxt_s;
         Instr_PC_OUT         <= instr_pc_nxt_s;
         Instr_PC_Plus4_OUT   <= instr_pc4_nxt_s;
         Pred_Taken_OUT       <= pred_nxt_s;
         Mispredict_Count_OUT <= count_nxt_s;
         if (shadow_adv_s) begin
            shadow_taken_r  <= Pred_Taken_OUT;
            shadow_target_r <= stage_target_r;
         end else begin
            shadow_taken_r  <= shadow_taken_r;
            shadow_target_r <= shadow_target_r;
         end
      end
   end

   // BTB valid bits: the only BTB state that needs clearing on reset
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid_r[i] <= 1'b0;
         end
      end else if (Resolve_Valid_IN && Resolve_Taken_IN) begin
         btb_valid_r[up_idx_s] <= 1'b1;
      end else begin
         btb_valid_r[up_idx_s] <= btb_valid_r[up_idx_s];
      end
   end

   // BTB tag/target/counter training from decode resolves
   always_ff @(posedge CLK) begin
      if (Resolve_Valid_IN) begin
         if (Resolve_Taken_IN) begin
            btb_tag_r[up_idx_s]    <= up_tag_s;
            btb_target_r[up_idx_s] <= Resolve_Target_IN;
            if (!up_hit_s) begin
               btb_ctr_r[up_idx_s] <= 2'b10;
            end else if (up_ctr_s != 2'b11) begin
               btb_ctr_r[up_idx_s] <= up_ctr_s + 2'd1;
            end else begin
               btb_ctr_r[up_idx_s] <= up_ctr_s;
            end
         end else if (up_hit_s && (up_ctr_s != 2'b00)) begin
            btb_ctr_r[up_idx_s] <= up_ctr_s - 2'd1;
         end else begin
            btb_ctr_r[up_idx_s] <= up_ctr_s;
         end
      end
   end

endmodule
